fetch_unit: RTL and testbench

Instruction fetch stage of the simple CPU, sitting directly upstream of the 64x8 program ROM and downstream-facing to the decode/execute logic. It owns the program counter, sequences the ROM's level-sensitive `read`/`ena` strobes so the address is stable before data is requested, and captures the returned byte into an instruction register. It presents that byte to decode through a valid/ready handshake. It accepts a PC redirect for jumps.

---
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, sequences ROM strobes (address settles before read),
// captures the returned byte and offers it to decode over a valid/ready handshake.
module fetch_unit #(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned PROG_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_read,
    output logic              rom_ena,
    output logic [DATA_W-1:0] instr,
    output logic [1:0]        opcode,
    output logic [ADDR_W-1:0] operand,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StRead,
        StCap,
        StHold
    } state_e;

    localparam logic [ADDR_W-1:0] PcLast = ADDR_W'(PROG_LEN - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_read_q, rom_read_d;
    logic              rom_ena_q, rom_ena_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic [ADDR_W-1:0] pc_next;

    assign pc_next = (pc_q == PcLast) ? '0 : pc_q + ADDR_W'(1);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rom_addr_d = rom_addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        unique case (state_q)
            StIdle: if (run) state_d = StAddr;
            StAddr: state_d = StRead;
            StRead: state_d = StCap;
            StCap: begin
                state_d    = StHold;
                instr_d    = rom_data;
                instr_pc_d = pc_q;
                pc_d       = pc_next;
            end
            StHold: if (instr_ready) state_d = run ? StAddr : StIdle;
            default: state_d = StIdle;
        endcase

        // A jump discards whatever is in flight, including a capture on this edge.
        if (jump_en) begin
            pc_d       = jump_addr;
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
            state_d    = run ? StAddr : StIdle;
        end

        // Address is only loaded on entry to ADDR so it is stable through READ and CAP.
        if (state_d == StAddr) rom_addr_d = pc_d;

        // Strobes are decoded from the next state so the registered copies track state_q.
        rom_ena_d     = (state_d == StAddr) || (state_d == StRead) || (state_d == StCap);
        rom_read_d    = (state_d == StRead) || (state_d == StCap);
        instr_valid_d = (state_d == StHold);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            pc_q          <= '0;
            rom_addr_q    <= '0;
            rom_read_q    <= 1'b0;
            rom_ena_q     <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rom_addr_q    <= rom_addr_d;
            rom_read_q    <= rom_read_d;
            rom_ena_q     <= rom_ena_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign rom_read    = rom_read_q;
    assign rom_ena     = rom_ena_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[DATA_W-1 -: 2];
    assign operand     = instr_q[ADDR_W-1:0];
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked by a
// transaction-level scoreboard of delivered (pc, instr) pairs.
module tb_fetch_unit;

    localparam int PROG_LEN = 8;

    logic       clk = 1'b0;
    logic       rst, run, jump_en, instr_ready;
    logic [5:0] jump_addr;
    logic [7:0] rom_data;
    logic [5:0] rom_addr, operand, instr_pc;
    logic       rom_read, rom_ena, instr_valid;
    logic [7:0] instr;
    logic [1:0] opcode;

    logic [7:0] rom [64];
    int tests = 0;
    int fails = 0;

    fetch_unit #(.ADDR_W(6), .DATA_W(8), .PROG_LEN(PROG_LEN)) dut (
        .clk(clk), .rst(rst), .run(run), .jump_en(jump_en), .jump_addr(jump_addr),
        .rom_data(rom_data), .rom_addr(rom_addr), .rom_read(rom_read), .rom_ena(rom_ena),
        .instr(instr), .opcode(opcode), .operand(operand), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    // Behavioural ROM: drives data only while both strobes are high.
    assign rom_data = (rom_read && rom_ena) ? rom[rom_addr] : 8'bz;

    function automatic logic [5:0] next_pc(input logic [5:0] p);
        int q;
        q = (int'(p) == PROG_LEN - 1) ? 0 : (int'(p) + 1) % 64;
        return 6'(q);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; jump_addr = '0;
        tick();
        rst = 1'b0;
    endtask

    // Bounded wait: returns after at most 20 edges; caller checks instr_valid.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!instr_valid && cyc < 20);
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({rom_addr, rom_read, rom_ena, instr, instr_pc, instr_valid} !== 23'd0)
            begin fails++; $display("FAIL reset_values: got %h want 0",
                {rom_addr, rom_read, rom_ena, instr, instr_pc, instr_valid}); end
        tick(); tick();
        tests++;
        if (rom_ena !== 1'b0 || rom_read !== 1'b0 || instr_valid !== 1'b0)
            begin fails++; $display("FAIL idle_no_run: ena=%b read=%b valid=%b want 000",
                rom_ena, rom_read, instr_valid); end
    endtask

    task automatic test_stream();
        int cyc;
        logic [5:0] ep;
        do_reset();
        instr_ready = 1'b1; run = 1'b1;
        tick();
        tests++;
        if ({rom_ena, rom_read, rom_addr, instr_valid} !== {1'b1, 1'b0, 6'd0, 1'b0})
            begin fails++; $display("FAIL stream_addr_phase: ena=%b read=%b addr=%0d valid=%b",
                rom_ena, rom_read, rom_addr, instr_valid); end
        tick();
        tests++;
        if ({rom_ena, rom_read, instr_valid} !== 3'b110)
            begin fails++; $display("FAIL stream_read_phase: ena=%b read=%b valid=%b want 110",
                rom_ena, rom_read, instr_valid); end
        tick(); tick();
        tests++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 6'd0, rom[0]})
            begin fails++; $display("FAIL stream_first_latency: valid=%b pc=%0d instr=%h want 1 0 %h",
                instr_valid, instr_pc, instr, rom[0]); end
        for (int k = 1; k <= 9; k++) begin
            wait_valid(cyc);
            ep = 6'(k % PROG_LEN);
            tests++;
            if (cyc != 4 || instr_valid !== 1'b1 || instr_pc !== ep || instr !== rom[ep])
                begin fails++; $display("FAIL stream_%0d: cyc=%0d pc=%0d instr=%h want 4 %0d %h",
                    k, cyc, instr_pc, instr, ep, rom[ep]); end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        do_reset();
        instr_ready = 1'b1; run = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_valid(cyc);
            if (instr_pc == 6'd4) begin instr_ready = 1'b0; break; end
        end
        for (int k = 0; k < 6; k++) begin
            tests++;
            if ({instr_valid, instr_pc, instr, opcode, operand} !== {1'b1, 6'd4, 8'hC3, 2'd3, 6'd3})
                begin fails++; $display("FAIL hold_%0d: valid=%b pc=%0d instr=%h op=%0d opnd=%0d",
                    k, instr_valid, instr_pc, instr, opcode, operand); end
            if (k < 5) tick();
        end
        instr_ready = 1'b1;
        wait_valid(cyc);
        tests++;
        if (cyc != 4 || instr_valid !== 1'b1 || instr_pc !== 6'd5 || instr !== 8'hC2)
            begin fails++; $display("FAIL after_hold: cyc=%0d pc=%0d instr=%h want 4 5 c2",
                cyc, instr_pc, instr); end
    endtask

    task automatic test_jump();
        int cyc;
        do_reset();
        instr_ready = 1'b1; run = 1'b1;
        wait_valid(cyc);
        wait_valid(cyc);
        tick();
        tests++;
        if ({rom_addr, rom_ena, rom_read} !== {6'd2, 1'b1, 1'b0})
            begin fails++; $display("FAIL jump_pre_addr: addr=%0d ena=%b read=%b want 2 1 0",
                rom_addr, rom_ena, rom_read); end
        tick();
        jump_en = 1'b1; jump_addr = 6'd6;
        tick();
        jump_en = 1'b0;
        tests++;
        if ({rom_addr, rom_ena, rom_read, instr_valid} !== {6'd6, 1'b1, 1'b0, 1'b0})
            begin fails++; $display("FAIL jump_redirect: addr=%0d ena=%b read=%b valid=%b",
                rom_addr, rom_ena, rom_read, instr_valid); end
        wait_valid(cyc);
        tests++;
        if (cyc != 3 || instr_valid !== 1'b1 || instr_pc !== 6'd6 || instr !== 8'hC3)
            begin fails++; $display("FAIL jump_target: cyc=%0d pc=%0d instr=%h want 3 6 c3",
                cyc, instr_pc, instr); end
        wait_valid(cyc);
        tests++;
        if (cyc != 4 || instr_pc !== 6'd7 || instr !== 8'hC2)
            begin fails++; $display("FAIL jump_follow: cyc=%0d pc=%0d instr=%h want 4 7 c2",
                cyc, instr_pc, instr); end
    endtask

    task automatic test_jump_handshake();
        int cyc;
        do_reset();
        instr_ready = 1'b1; run = 1'b1;
        wait_valid(cyc);
        jump_en = 1'b1; jump_addr = 6'd5;
        tick();
        jump_en = 1'b0;
        tests++;
        if ({instr_valid, rom_addr, rom_ena} !== {1'b0, 6'd5, 1'b1})
            begin fails++; $display("FAIL jhs_redirect: valid=%b addr=%0d ena=%b want 0 5 1",
                instr_valid, rom_addr, rom_ena); end
        wait_valid(cyc);
        tests++;
        if (cyc != 3 || instr_pc !== 6'd5 || instr !== 8'hC2)
            begin fails++; $display("FAIL jhs_target: cyc=%0d pc=%0d instr=%h want 3 5 c2",
                cyc, instr_pc, instr); end
        wait_valid(cyc);
        tests++;
        if (instr_pc !== 6'd6 || instr !== 8'hC3)
            begin fails++; $display("FAIL jhs_follow: pc=%0d instr=%h want 6 c3", instr_pc, instr); end
    endtask

    task automatic test_run_drop();
        int cyc;
        do_reset();
        instr_ready = 1'b1; run = 1'b1;
        wait_valid(cyc);
        tick();
        run = 1'b0;
        wait_valid(cyc);
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 6'd1 || instr !== 8'h82)
            begin fails++; $display("FAIL drop_deliver: valid=%b pc=%0d instr=%h want 1 1 82",
                instr_valid, instr_pc, instr); end
        tick(); tick(); tick();
        tests++;
        if ({rom_ena, rom_read, instr_valid} !== 3'b000)
            begin fails++; $display("FAIL drop_idle: ena=%b read=%b valid=%b want 000",
                rom_ena, rom_read, instr_valid); end
        run = 1'b1;
        wait_valid(cyc);
        tests++;
        if (cyc != 4 || instr_pc !== 6'd2 || instr !== 8'h43)
            begin fails++; $display("FAIL drop_resume: cyc=%0d pc=%0d instr=%h want 4 2 43",
                cyc, instr_pc, instr); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        do_reset();
        instr_ready = 1'b1; run = 1'b1;
        wait_valid(cyc);
        tick(); tick(); tick();
        rst = 1'b1; run = 1'b0;
        tick();
        rst = 1'b0;
        tests++;
        if ({rom_addr, rom_read, rom_ena, instr, instr_pc, instr_valid} !== 23'd0)
            begin fails++; $display("FAIL reset_mid: got %h want 0",
                {rom_addr, rom_read, rom_ena, instr, instr_pc, instr_valid}); end
        run = 1'b1;
        wait_valid(cyc);
        tests++;
        if (cyc != 4 || instr_pc !== 6'd0 || instr !== 8'h43)
            begin fails++; $display("FAIL reset_restart: cyc=%0d pc=%0d instr=%h want 4 0 43",
                cyc, instr_pc, instr); end
    endtask

    task automatic test_random();
        logic [5:0] exp_pc;
        logic [5:0] prev_addr;
        int delivered;
        do_reset();
        exp_pc = '0; delivered = 0; prev_addr = rom_addr;
        for (int i = 0; i < 800; i++) begin
            run         = ($urandom_range(0, 9) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            jump_en     = ($urandom_range(0, 24) == 0);
            jump_addr   = 6'($urandom_range(0, 63));
            if (instr_valid && instr_ready) begin
                tests++;
                if (instr_pc !== exp_pc || instr !== rom[exp_pc])
                    begin fails++; $display("FAIL rand_deliver@%0d: pc=%0d instr=%h want %0d %h",
                        i, instr_pc, instr, exp_pc, rom[exp_pc]); end
                delivered++;
                exp_pc = next_pc(exp_pc);
            end
            if (jump_en) exp_pc = jump_addr;
            if (rom_read) begin
                tests++;
                if (rom_addr !== prev_addr)
                    begin fails++; $display("FAIL rand_addr_stable@%0d: addr=%0d prev=%0d",
                        i, rom_addr, prev_addr); end
            end
            prev_addr = rom_addr;
            tick();
        end
        jump_en = 1'b0;
        tests++;
        if (delivered < 20)
            begin fails++; $display("FAIL rand_progress: delivered=%0d want >=20", delivered); end
    endtask

    initial begin
        logic [7:0] init_vals [8];
        init_vals = '{8'h43, 8'h82, 8'h43, 8'h82, 8'hC3, 8'hC2, 8'hC3, 8'hC2};
        for (int a = 0; a < 64; a++) rom[a] = (a < 8) ? init_vals[a] : 8'($urandom);
        rst = 1'b1; run = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; jump_addr = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_jump();
        test_jump_handshake();
        test_run_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
